// File: rtl/fineps_controller.sv
// Fine phase-shift responder: turns one incr/decr request into a single MMCM PSEN pulse and tracks the phase position.
// Optional PSDONE watchdog is compiled in when FINEPS_TIMEOUT_EN is defined.
module fineps_controller #(
    parameter int PHASE_WRAP     = 504,
    parameter int PHASE_CNT_W    = 10,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   in_fineps_clk,
    input  logic                   in_rst_n,
    input  logic                   in_locked,
    input  logic                   in_fineps_incr,
    input  logic                   in_fineps_decr,
    input  logic                   in_fineps_valid,
    output logic                   out_fineps_dready,
    output logic                   out_psen,
    output logic                   out_psincdec,
    input  logic                   in_psdone,
    output logic                   out_ps_done,
    output logic [PHASE_CNT_W-1:0] out_phase_pos,
    output logic                   out_timeout_err
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [PHASE_CNT_W-1:0] POS_MAX     = PHASE_CNT_W'(PHASE_WRAP - 1);
    localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_READY,
        S_ISSUE,
        S_WAIT_DONE,
        S_SETTLE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    dready_nxt, psen_nxt, psincdec_nxt, ps_done_nxt;
    logic [PHASE_CNT_W-1:0]  pos_nxt, pos_inc, pos_dec;

    assign pos_inc = (out_phase_pos == POS_MAX) ? '0 : out_phase_pos + 1'b1;
    assign pos_dec = (out_phase_pos == '0) ? POS_MAX : out_phase_pos - 1'b1;

`ifdef FINEPS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    logic timeout_hit;

    always_ff @(posedge in_fineps_clk or negedge in_rst_n) begin
        if (!in_rst_n)
            out_timeout_err <= 1'b0;
        else if (timeout_hit)
            out_timeout_err <= 1'b1;
    end
`else
    assign out_timeout_err = 1'b0;
`endif

    always_ff @(posedge in_fineps_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state             <= S_WAIT_LOCK;
            cnt               <= '0;
            out_fineps_dready <= 1'b0;
            out_psen          <= 1'b0;
            out_psincdec      <= 1'b0;
            out_ps_done       <= 1'b0;
            out_phase_pos     <= '0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            out_fineps_dready <= dready_nxt;
            out_psen          <= psen_nxt;
            out_psincdec      <= psincdec_nxt;
            out_ps_done       <= ps_done_nxt;
            out_phase_pos     <= pos_nxt;
        end
    end

    // Lock loss overrides everything: the MMCM restarts its phase, so the position returns to zero.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dready_nxt   = out_fineps_dready;
        psen_nxt     = 1'b0;
        psincdec_nxt = out_psincdec;
        ps_done_nxt  = 1'b0;
        pos_nxt      = out_phase_pos;
`ifdef FINEPS_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        if (!in_locked) begin
            state_nxt  = S_WAIT_LOCK;
            dready_nxt = 1'b0;
            pos_nxt    = '0;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    state_nxt  = S_READY;
                    dready_nxt = 1'b1;
                end
                S_READY: begin
                    if (in_fineps_valid && out_fineps_dready && (in_fineps_incr ^ in_fineps_decr)) begin
                        state_nxt    = S_ISSUE;
                        psen_nxt     = 1'b1;
                        psincdec_nxt = in_fineps_incr;
                        dready_nxt   = 1'b0;
                    end
                end
                S_ISSUE: begin
                    state_nxt = S_WAIT_DONE;
                    cnt_nxt   = '0;
                end
                S_WAIT_DONE: begin
                    if (in_psdone) begin
                        ps_done_nxt = 1'b1;
                        pos_nxt     = out_psincdec ? pos_inc : pos_dec;
                        cnt_nxt     = '0;
                        if (SETTLE_CYCLES == 0) begin
                            state_nxt  = S_READY;
                            dready_nxt = 1'b1;
                        end else begin
                            state_nxt = S_SETTLE;
                        end
                    end
`ifdef FINEPS_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
                        state_nxt   = S_READY;
                        dready_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_nxt  = S_READY;
                        dready_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt  = S_WAIT_LOCK;
                    dready_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule
